axi_lite_arbiter2: RTL and testbench

- Two-master to one-slave AXI4-Lite arbiter in front of the MMU core port.
- Master 0 is instruction fetch and master 1 is the load/store unit. Both share the single core bus that the MMU decodes to RAM or UART.
- One transaction is outstanding at a time. Default policy is round-robin.
- The arbiter registers the request, replays it on the slave port, and routes the response back to the granted master only.

---
 rtl/axi_lite_arbiter2_pkg.sv | 21 ++
 rtl/axi_lite_arbiter2_rr_pick2.sv | 30 +++
 rtl/axi_lite_arbiter2.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_lite_arbiter2.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arbiter2_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
// Optional AXI_ARB_FIXED_PRIO_EN is consumed by rr_pick2.
package axi_arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      RD_RESP = 3'd3,
      WR_ADDR = 3'd4,
      WR_DATA = 3'd5,
      WR_RESP = 3'd6
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic GRANT_M0 = 1'b0;
   localparam logic GRANT_M1 = 1'b1;

endpackage

// File: rtl/axi_lite_arbiter2_rr_pick2.sv
// Two-way winner select. Round-robin on ties by default; with
// AXI_ARB_FIXED_PRIO_EN defined, master 1 always wins a tie.
module rr_pick2
   import axi_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic grant_o
);

`ifdef AXI_ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant_i;
`endif

   always_comb begin
      grant_o = GRANT_M0;
      if (req0_i && req1_i) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
         grant_o = GRANT_M1;
`else
         grant_o = ~last_grant_i;
`endif
      end else if (req1_i) begin
         grant_o = GRANT_M1;
      end
   end

endmodule

// File: rtl/axi_lite_arbiter2.sv
// Two-master to one-slave AXI4-Lite arbiter, one transaction in flight.
// Tie policy set by AXI_ARB_FIXED_PRIO_EN (see rr_pick2).
module axi_lite_arbiter2
   import axi_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   // master 0 (instruction fetch)
   input  logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
   input  logic [2:0]              m0_axi_arprot,
   input  logic                    m0_axi_arvalid,
   output logic                    m0_axi_arready,
   output logic [DATA_WIDTH-1:0]   m0_axi_rdata,
   output logic [1:0]              m0_axi_rresp,
   output logic                    m0_axi_rvalid,
   input  logic                    m0_axi_rready,
   input  logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
   input  logic [2:0]              m0_axi_awprot,
   input  logic                    m0_axi_awvalid,
   output logic                    m0_axi_awready,
   input  logic [DATA_WIDTH-1:0]   m0_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
   input  logic                    m0_axi_wvalid,
   output logic                    m0_axi_wready,
   output logic [1:0]              m0_axi_bresp,
   output logic                    m0_axi_bvalid,
   input  logic                    m0_axi_bready,
   // master 1 (load/store)
   input  logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
   input  logic [2:0]              m1_axi_arprot,
   input  logic                    m1_axi_arvalid,
   output logic                    m1_axi_arready,
   output logic [DATA_WIDTH-1:0]   m1_axi_rdata,
   output logic [1:0]              m1_axi_rresp,
   output logic                    m1_axi_rvalid,
   input  logic                    m1_axi_rready,
   input  logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
   input  logic [2:0]              m1_axi_awprot,
   input  logic                    m1_axi_awvalid,
   output logic                    m1_axi_awready,
   input  logic [DATA_WIDTH-1:0]   m1_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
   input  logic                    m1_axi_wvalid,
   output logic                    m1_axi_wready,
   output logic [1:0]              m1_axi_bresp,
   output logic                    m1_axi_bvalid,
   input  logic                    m1_axi_bready,
   // slave (MMU core port)
   output logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   output logic [2:0]              s_axi_arprot,
   output logic                    s_axi_arvalid,
   input  logic                    s_axi_arready,
   input  logic [DATA_WIDTH-1:0]   s_axi_rdata,
   input  logic [1:0]              s_axi_rresp,
   input  logic                    s_axi_rvalid,
   output logic                    s_axi_rready,
   output logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   output logic [2:0]              s_axi_awprot,
   output logic                    s_axi_awvalid,
   input  logic                    s_axi_awready,
   output logic [DATA_WIDTH-1:0]   s_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   output logic                    s_axi_wvalid,
   input  logic                    s_axi_wready,
   input  logic [1:0]              s_axi_bresp,
   input  logic                    s_axi_bvalid,
   output logic                    s_axi_bready
);

   localparam int STRB_W = DATA_WIDTH / 8;

   state_t                  state_q, state_d;
   logic                    grant_q, grant_d;
   logic                    last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [2:0]              prot_q, prot_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic [1:0]              bresp_q, bresp_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;

   logic                    req0, req1, win;
   logic                    win_rd, aw_fin, w_fin;
   logic [1:0]              arready_v, awready_v, wready_v, rvalid_v, bvalid_v;
   logic [1:0]              rready_v, bready_v;

   // A master requests with a read address, or with a complete write pair.
   assign req0 = m0_axi_arvalid | (m0_axi_awvalid & m0_axi_wvalid);
   assign req1 = m1_axi_arvalid | (m1_axi_awvalid & m1_axi_wvalid);

   rr_pick2 u_pick (
      .req0_i       (req0),
      .req1_i       (req1),
      .last_grant_i (last_grant_q),
      .grant_o      (win)
   );

   assign win_rd   = win ? m1_axi_arvalid : m0_axi_arvalid;
   assign rready_v = {m1_axi_rready, m0_axi_rready};
   assign bready_v = {m1_axi_bready, m0_axi_bready};
   assign aw_fin   = aw_done_q | s_axi_awready;
   assign w_fin    = w_done_q | s_axi_wready;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      addr_d        = addr_q;
      prot_d        = prot_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      rdata_d       = rdata_q;
      rresp_d       = rresp_q;
      bresp_d       = bresp_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      arready_v     = 2'b00;
      awready_v     = 2'b00;
      wready_v      = 2'b00;
      rvalid_v      = 2'b00;
      bvalid_v      = 2'b00;
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b0;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b0;
      case (state_q)
         IDLE: begin
            // Accept only outside reset so a held request is not lost.
            if ((req0 || req1) && !rst) begin
               grant_d   = win;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (win_rd) begin
                  arready_v[win] = 1'b1;
                  addr_d         = win ? m1_axi_araddr : m0_axi_araddr;
                  prot_d         = win ? m1_axi_arprot : m0_axi_arprot;
                  state_d        = RD_ADDR;
               end else begin
                  awready_v[win] = 1'b1;
                  wready_v[win]  = 1'b1;
                  addr_d         = win ? m1_axi_awaddr : m0_axi_awaddr;
                  prot_d         = win ? m1_axi_awprot : m0_axi_awprot;
                  wdata_d        = win ? m1_axi_wdata  : m0_axi_wdata;
                  wstrb_d        = win ? m1_axi_wstrb  : m0_axi_wstrb;
                  state_d        = WR_ADDR;
               end
            end
         end
         RD_ADDR: begin
            s_axi_arvalid = 1'b1;
            if (s_axi_arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            s_axi_rready = 1'b1;
            if (s_axi_rvalid) begin
               rdata_d = s_axi_rdata;
               rresp_d = s_axi_rresp;
               state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            rvalid_v[grant_q] = 1'b1;
            if (rready_v[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         WR_ADDR: begin
            // Address and data channels complete independently.
            s_axi_awvalid = !aw_done_q;
            s_axi_wvalid  = !w_done_q;
            aw_done_d     = aw_fin;
            w_done_d      = w_fin;
            if (aw_fin && w_fin) state_d = WR_DATA;
         end
         WR_DATA: begin
            s_axi_bready = 1'b1;
            if (s_axi_bvalid) begin
               bresp_d = s_axi_bresp;
               state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            bvalid_v[grant_q] = 1'b1;
            if (bready_v[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= GRANT_M0;
         last_grant_q <= GRANT_M1;
         addr_q       <= '0;
         prot_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         rdata_q      <= '0;
         rresp_q      <= '0;
         bresp_q      <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         prot_q       <= prot_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         rdata_q      <= rdata_d;
         rresp_q      <= rresp_d;
         bresp_q      <= bresp_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
      end
   end

   assign s_axi_araddr = addr_q;
   assign s_axi_arprot = prot_q;
   assign s_axi_awaddr = addr_q;
   assign s_axi_awprot = prot_q;
   assign s_axi_wdata  = wdata_q;
   assign s_axi_wstrb  = wstrb_q;

   assign m0_axi_arready = arready_v[0];
   assign m1_axi_arready = arready_v[1];
   assign m0_axi_awready = awready_v[0];
   assign m1_axi_awready = awready_v[1];
   assign m0_axi_wready  = wready_v[0];
   assign m1_axi_wready  = wready_v[1];
   assign m0_axi_rvalid  = rvalid_v[0];
   assign m1_axi_rvalid  = rvalid_v[1];
   assign m0_axi_bvalid  = bvalid_v[0];
   assign m1_axi_bvalid  = bvalid_v[1];

   // Response payload is shown only to the granted master.
   assign m0_axi_rdata = (grant_q == GRANT_M0) ? rdata_q : '0;
   assign m1_axi_rdata = (grant_q == GRANT_M1) ? rdata_q : '0;
   assign m0_axi_rresp = (grant_q == GRANT_M0) ? rresp_q : '0;
   assign m1_axi_rresp = (grant_q == GRANT_M1) ? rresp_q : '0;
   assign m0_axi_bresp = (grant_q == GRANT_M0) ? bresp_q : '0;
   assign m1_axi_bresp = (grant_q == GRANT_M1) ? bresp_q : '0;

endmodule

// File: tb/tb_axi_lite_arbiter2.sv
// Directed bench for axi_lite_arbiter2 with a small configurable slave model.
module tb_axi_lite_arbiter2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [31:0] m_araddr [2];
   logic [2:0]  m_arprot [2];
   logic        m_arvalid[2];
   logic        m_arready[2];
   logic [31:0] m_rdata  [2];
   logic [1:0]  m_rresp  [2];
   logic        m_rvalid [2];
   logic        m_rready [2];
   logic [31:0] m_awaddr [2];
   logic [2:0]  m_awprot [2];
   logic        m_awvalid[2];
   logic        m_awready[2];
   logic [31:0] m_wdata  [2];
   logic [3:0]  m_wstrb  [2];
   logic        m_wvalid [2];
   logic        m_wready [2];
   logic [1:0]  m_bresp  [2];
   logic        m_bvalid [2];
   logic        m_bready [2];

   logic [31:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata, s_axi_rdata;
   logic [2:0]  s_axi_arprot, s_axi_awprot;
   logic [3:0]  s_axi_wstrb;
   logic [1:0]  s_axi_rresp, s_axi_bresp;
   logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
   logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic        s_axi_bvalid, s_axi_bready;

   int checks = 0;
   int errors = 0;

   // slave configuration and observations
   logic [31:0] slv_rdata = '0;
   logic [1:0]  slv_rresp = 2'b00;
   logic [1:0]  slv_bresp = 2'b00;
   int          slv_aw_delay = 0;
   int          slv_w_delay = 0;
   bit          slv_hold_r = 0;
   logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
   logic [3:0]  cap_wstrb = '0;
   int          aw_vcnt = 0, w_vcnt = 0;

   longint acc_t[2], rd_done_t[2], wr_acc_t[2], wr_done_t[2];

   always #5 clk = ~clk;

   axi_lite_arbiter2 dut (
      .clk(clk), .rst(rst),
      .m0_axi_araddr(m_araddr[0]), .m0_axi_arprot(m_arprot[0]), .m0_axi_arvalid(m_arvalid[0]),
      .m0_axi_arready(m_arready[0]), .m0_axi_rdata(m_rdata[0]), .m0_axi_rresp(m_rresp[0]),
      .m0_axi_rvalid(m_rvalid[0]), .m0_axi_rready(m_rready[0]), .m0_axi_awaddr(m_awaddr[0]),
      .m0_axi_awprot(m_awprot[0]), .m0_axi_awvalid(m_awvalid[0]), .m0_axi_awready(m_awready[0]),
      .m0_axi_wdata(m_wdata[0]), .m0_axi_wstrb(m_wstrb[0]), .m0_axi_wvalid(m_wvalid[0]),
      .m0_axi_wready(m_wready[0]), .m0_axi_bresp(m_bresp[0]), .m0_axi_bvalid(m_bvalid[0]),
      .m0_axi_bready(m_bready[0]),
      .m1_axi_araddr(m_araddr[1]), .m1_axi_arprot(m_arprot[1]), .m1_axi_arvalid(m_arvalid[1]),
      .m1_axi_arready(m_arready[1]), .m1_axi_rdata(m_rdata[1]), .m1_axi_rresp(m_rresp[1]),
      .m1_axi_rvalid(m_rvalid[1]), .m1_axi_rready(m_rready[1]), .m1_axi_awaddr(m_awaddr[1]),
      .m1_axi_awprot(m_awprot[1]), .m1_axi_awvalid(m_awvalid[1]), .m1_axi_awready(m_awready[1]),
      .m1_axi_wdata(m_wdata[1]), .m1_axi_wstrb(m_wstrb[1]), .m1_axi_wvalid(m_wvalid[1]),
      .m1_axi_wready(m_wready[1]), .m1_axi_bresp(m_bresp[1]), .m1_axi_bvalid(m_bvalid[1]),
      .m1_axi_bready(m_bready[1]),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready)
   );

   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit other_busy(input int o);
      return m_rvalid[o] | m_bvalid[o] | m_arready[o] | m_awready[o] | m_wready[o];
   endfunction

   // Slave: samples handshakes at negedge, updates its drives just after posedge.
   initial begin
      bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rst_s, r_pend, got_aw, got_w;
      int aw_age, w_age;
      r_pend = 0; got_aw = 0; got_w = 0; aw_age = 0; w_age = 0;
      s_axi_arready = 1'b1; s_axi_rvalid = 1'b0; s_axi_rdata = '0; s_axi_rresp = '0;
      s_axi_awready = 1'b1; s_axi_wready = 1'b1; s_axi_bvalid = 1'b0; s_axi_bresp = '0;
      forever begin
         @(negedge clk);
         rst_s = rst;
         ar_hs = s_axi_arvalid & s_axi_arready;
         r_hs  = s_axi_rvalid & s_axi_rready;
         aw_hs = s_axi_awvalid & s_axi_awready;
         w_hs  = s_axi_wvalid & s_axi_wready;
         b_hs  = s_axi_bvalid & s_axi_bready;
         aw_vcnt += int'(s_axi_awvalid);
         w_vcnt  += int'(s_axi_wvalid);
         if (ar_hs) cap_araddr = s_axi_araddr;
         if (aw_hs) cap_awaddr = s_axi_awaddr;
         if (w_hs) begin cap_wdata = s_axi_wdata; cap_wstrb = s_axi_wstrb; end
         if (s_axi_awvalid && !s_axi_awready) aw_age++; else if (aw_hs) aw_age = 0;
         if (s_axi_wvalid && !s_axi_wready) w_age++; else if (w_hs) w_age = 0;
         @(posedge clk); #1;
         if (rst_s) begin
            r_pend = 0; got_aw = 0; got_w = 0; aw_age = 0; w_age = 0;
            s_axi_rvalid = 1'b0; s_axi_bvalid = 1'b0;
         end else begin
            if (r_hs) s_axi_rvalid = 1'b0;
            if (ar_hs) r_pend = 1;
            if (r_pend && !slv_hold_r && !s_axi_rvalid) begin
               s_axi_rvalid = 1'b1;
               s_axi_rdata  = slv_rdata ^ cap_araddr;
               s_axi_rresp  = slv_rresp;
               r_pend = 0;
            end
            if (b_hs) s_axi_bvalid = 1'b0;
            got_aw |= aw_hs;
            got_w  |= w_hs;
            if (got_aw && got_w && !s_axi_bvalid) begin
               s_axi_bvalid = 1'b1; s_axi_bresp = slv_bresp; got_aw = 0; got_w = 0;
            end
         end
         s_axi_awready = (aw_age >= slv_aw_delay);
         s_axi_wready  = (w_age >= slv_w_delay);
      end
   end

   // Full read on master m; starts just after a posedge, ends just after one.
   task automatic read_txn(input int m, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int low_cycles, input int exp_lat,
                           input bit quiet_chk, input string tag);
      int lat; bit ok, stable, quiet; logic [31:0] d0;
      quiet = 1; ok = 0;
      m_araddr[m] = addr; m_arprot[m] = 3'b001; m_arvalid[m] = 1'b1;
      m_rready[m] = (low_cycles == 0);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (other_busy(1 - m)) quiet = 0;
         if (m_arready[m]) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      acc_t[m] = $time;
      chk(64'(ok), 64'd1, {tag, " ar accept"});
      @(posedge clk); #1;
      m_arvalid[m] = 1'b0;
      lat = 1; ok = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         lat++;
         if (other_busy(1 - m)) quiet = 0;
         if (m_rvalid[m]) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk(64'(ok), 64'd1, {tag, " rvalid"});
      stable = 1; d0 = m_rdata[m];
      for (int k = 1; k <= low_cycles; k++) begin
         @(posedge clk); #1;
         if (k == low_cycles) m_rready[m] = 1'b1;
         @(negedge clk);
         lat++;
         if (!m_rvalid[m] || m_rdata[m] !== d0) stable = 0;
      end
      if (low_cycles > 0) chk(64'(stable), 64'd1, {tag, " rvalid/rdata stable"});
      chk(64'(m_rdata[m]), 64'(exp_data), {tag, " rdata"});
      chk(64'(m_rresp[m]), 64'(exp_resp), {tag, " rresp"});
      if (exp_lat > 0) chk(64'(lat), 64'(exp_lat), {tag, " latency"});
      rd_done_t[m] = $time;
      @(posedge clk); #1;
      m_rready[m] = 1'b0;
      if (quiet_chk) chk(64'(quiet), 64'd1, {tag, " other master quiet"});
   endtask

   task automatic write_txn(input int m, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp, input int exp_lat,
                            input bit quiet_chk, input string tag);
      int lat; bit ok, quiet;
      quiet = 1; ok = 0;
      m_awaddr[m] = addr; m_awprot[m] = 3'b000; m_awvalid[m] = 1'b1;
      m_wdata[m] = data; m_wstrb[m] = strb; m_wvalid[m] = 1'b1; m_bready[m] = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (other_busy(1 - m)) quiet = 0;
         if (m_awready[m]) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      wr_acc_t[m] = $time;
      chk(64'(ok), 64'd1, {tag, " aw accept"});
      chk(64'(m_wready[m]), 64'd1, {tag, " wready with awready"});
      @(posedge clk); #1;
      m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0;
      lat = 1; ok = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         lat++;
         if (other_busy(1 - m)) quiet = 0;
         if (m_bvalid[m]) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk(64'(ok), 64'd1, {tag, " bvalid"});
      chk(64'(m_bresp[m]), 64'(exp_resp), {tag, " bresp"});
      if (exp_lat > 0) chk(64'(lat), 64'(exp_lat), {tag, " latency"});
      wr_done_t[m] = $time;
      @(posedge clk); #1;
      m_bready[m] = 1'b0;
      if (quiet_chk) chk(64'(quiet), 64'd1, {tag, " other master quiet"});
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic logic [14:0] all_handshake_outs();
      return {s_axi_arvalid, s_axi_rready, s_axi_awvalid, s_axi_wvalid, s_axi_bready,
              m_arready[0], m_arready[1], m_awready[0], m_awready[1], m_wready[0],
              m_wready[1], m_rvalid[0], m_rvalid[1], m_bvalid[0], m_bvalid[1]};
   endfunction

   initial begin
      bit ok;
      for (int i = 0; i < 2; i++) begin
         m_araddr[i] = '0; m_arprot[i] = '0; m_arvalid[i] = 1'b0; m_rready[i] = 1'b0;
         m_awaddr[i] = '0; m_awprot[i] = '0; m_awvalid[i] = 1'b0;
         m_wdata[i] = '0; m_wstrb[i] = '0; m_wvalid[i] = 1'b0; m_bready[i] = 1'b0;
      end

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(64'(all_handshake_outs()), 64'd0, "reset valids/readies");
      chk({s_axi_araddr, m_rdata[0]}, 64'd0, "reset addr/data regs");
      @(posedge clk); #1;
      rst = 1'b0;

      // lone m0 read, zero wait
      slv_rdata = 32'hDEAD_BEEF ^ 32'h0000_0100;
      read_txn(0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 0, 4, 1, "m0 read");
      chk(64'(cap_araddr), 64'h100, "slave araddr");

      // simultaneous reads straight after reset
      pulse_reset();
      slv_rdata = '0;
      fork
         read_txn(0, 32'h0000_0200, 32'h0000_0200, 2'b00, 0, 0, 0, "pairA m0");
         read_txn(1, 32'h0000_0300, 32'h0000_0300, 2'b00, 0, 0, 0, "pairA m1");
      join
`ifdef AXI_ARB_FIXED_PRIO_EN
      chk(64'(acc_t[0] < acc_t[1]), 64'd0, "pairA order (m1 first)");
`else
      chk(64'(acc_t[0] < acc_t[1]), 64'd1, "pairA order (m0 first)");
`endif
      // m0 served last -> next tie goes to m1 in both policies
      read_txn(0, 32'h0000_0204, 32'h0000_0204, 2'b00, 0, 4, 1, "m0 read 2");
      fork
         read_txn(0, 32'h0000_0208, 32'h0000_0208, 2'b00, 0, 0, 0, "pairB m0");
         read_txn(1, 32'h0000_0308, 32'h0000_0308, 2'b00, 0, 0, 0, "pairB m1");
      join
      chk(64'(acc_t[1] < acc_t[0]), 64'd1, "pairB order (m1 first)");

      // m1 write, wready trails awready by 2 cycles
      slv_w_delay = 2; aw_vcnt = 0; w_vcnt = 0;
      write_txn(1, 32'h0000_0044, 32'h1234_5678, 4'b0011, 2'b00, 6, 1, "m1 write");
      chk(64'(aw_vcnt), 64'd1, "s_awvalid cycles");
      chk(64'(w_vcnt), 64'd3, "s_wvalid cycles");
      chk({cap_awaddr, cap_wdata}, {32'h0000_0044, 32'h1234_5678}, "slave aw/w payload");
      chk(64'(cap_wstrb), 64'h3, "slave wstrb");

      // zero-wait write with SLVERR passthrough
      slv_w_delay = 0; slv_bresp = 2'b10;
      write_txn(0, 32'hF000_0000, 32'hCAFE_0001, 4'b1111, 2'b10, 4, 1, "m0 write slverr");
      slv_bresp = 2'b00;

      // m0 read and write pending together: read first
      fork
         read_txn(0, 32'h0000_0500, 32'h0000_0500, 2'b00, 0, 4, 0, "m0 rd+wr read");
         write_txn(0, 32'h0000_0600, 32'h0000_00AA, 4'b0001, 2'b00, 4, 0, "m0 rd+wr write");
      join
      chk(64'(wr_acc_t[0] > rd_done_t[0]), 64'd1, "write accepted after read done");

      // m1 stalls rready 5 cycles; m0 must wait
      slv_rresp = 2'b10;
      fork
         read_txn(1, 32'h0000_0700, 32'h0000_0700, 2'b10, 5, 9, 0, "m1 slow rready");
         begin
            repeat (2) @(posedge clk);
            #1;
            read_txn(0, 32'h0000_0800, 32'h0000_0800, 2'b10, 0, 0, 0, "m0 behind m1");
         end
      join
      chk(64'(acc_t[0] > rd_done_t[1]), 64'd1, "m0 un-acked until m1 done");
      slv_rresp = 2'b00;

      // reset while in RD_DATA
      slv_hold_r = 1;
      m_araddr[0] = 32'h0000_0900; m_arvalid[0] = 1'b1; ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (m_arready[0]) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk(64'(ok), 64'd1, "rst test accept");
      @(posedge clk); #1;
      m_arvalid[0] = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk(64'(s_axi_rready), 64'd1, "in RD_DATA before rst");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk(64'(all_handshake_outs()), 64'd0, "after mid-read rst");
      slv_hold_r = 0;
      @(posedge clk); #1;
      read_txn(0, 32'h0000_0A00, 32'h0000_0A00, 2'b00, 0, 4, 1, "m0 after rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
